// File: rtl/mux2_1_pipe_pkg.sv
// Shared constants and types for the mux2_1_pipe datapath selector.
package mux2_1_pipe_pkg;

  localparam int DEF_WIDTH = 64;

  typedef logic [DEF_WIDTH-1:0] word_t;

endpackage : mux2_1_pipe_pkg

// File: rtl/mux2_1_bit.sv
// Single-bit 2:1 multiplexer; replicated per bit by mux2_1_pipe.
module mux2_1_bit (
  output logic out,
  input  logic i0,
  input  logic i1,
  input  logic sel
);

  // Plain ternary keeps X on sel visible downstream.
  assign out = sel ? i1 : i0;

endmodule : mux2_1_bit

// File: rtl/mux2_1_pipe.sv
// 2:1 datapath mux with a combinational result and a valid/ready registered result.
// Define MUX2_1_PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module mux2_1_pipe
  import mux2_1_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] comb_out,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] sel_word;

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    mux2_1_bit u_bit (
      .out (sel_word[k]),
      .i0  (i0[k]),
      .i1  (i1[k]),
      .sel (sel)
    );
  end

  assign comb_out = sel_word;

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             in_fire;

  assign in_fire   = in_valid && in_ready;
  assign out_valid = main_valid_q;
  assign out       = main_data_q;

`ifdef MUX2_1_PIPE_SKID_EN

  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             in_ready_q,   in_ready_d;

  assign in_ready = in_ready_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!main_valid_q || out_ready) begin
      // Main is free or unloading: refill from skid first to keep order.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = sel_word;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = sel_word;
    end
    in_ready_d = !skid_valid_d;
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

`else

  logic rdy_en_q, rdy_en_d;

  // rdy_en_q holds in_ready low through reset and releases it one edge later.
  assign rdy_en_d = 1'b1;
  assign in_ready = rdy_en_q && (!main_valid_q || out_ready);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (in_fire) begin
      main_valid_d = 1'b1;
      main_data_d  = sel_word;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      rdy_en_q     <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      rdy_en_q     <= rdy_en_d;
    end
  end

`endif

endmodule : mux2_1_pipe

// File: tb/tb_mux2_1_pipe.sv
// Directed and scoreboard-checked bench for mux2_1_pipe (either build).
module tb_mux2_1_pipe;
  import mux2_1_pipe_pkg::*;

  localparam int WIDTH = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  word_t       i0, i1, comb_out, out;
  logic        sel, in_valid, in_ready, out_valid, out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  mux2_1_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i0        (i0),
    .i1        (i1),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .comb_out  (comb_out),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    word_t       sq[$];
    word_t       exp_w, held_w;
    logic        held_v;
    logic        s;
    logic        exp_rdy_stall0;
    word_t       sa0[8], sa1[8];

    reset_n   = 1'b0;
    i0        = '0;
    i1        = '0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out",       out,       '0);
    check("rst_in_ready",  in_ready,  1'b0);

    // Combinational path works while in reset, no clock edge needed.
    i1  = 64'hFFFF_FFFF_FFFF_FFFF;
    sel = 1'b0;
    #1;
    check("comb_sel0", comb_out, 64'h0);
    sel = 1'b1;
    #1;
    check("comb_sel1", comb_out, 64'hFFFF_FFFF_FFFF_FFFF);
    i0  = 64'h1234_5678_9ABC_DEF0;
    i1  = 64'h0F0F_0F0F_F0F0_F0F0;
    sel = 1'b0;
    #1;
    check("comb_mix", comb_out, 64'h1234_5678_9ABC_DEF0);

    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("rel_in_ready", in_ready, 1'b1);

    // Registered path, 1-cycle latency.
    sel = 1'b1; i1 = 64'hDEAD_BEEF_0123_4567; in_valid = 1'b1; out_ready = 1'b1;
    step();
    check("reg_out",       out,       64'hDEAD_BEEF_0123_4567);
    check("reg_out_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    step();
    check("drain_valid", out_valid, 1'b0);
    check("empty_hold",  out,       64'hDEAD_BEEF_0123_4567);

    // Stall: capture A5.., then hold out_ready low for 3 cycles with B offered.
    sel = 1'b0; i0 = 64'hA5A5_A5A5_A5A5_A5A5; in_valid = 1'b1; out_ready = 1'b0;
    step();
    check("stall_cap", out, 64'hA5A5_A5A5_A5A5_A5A5);
    i0 = 64'h5A5A_5A5A_5A5A_5A5A;
    #1;
`ifdef MUX2_1_PIPE_SKID_EN
    exp_rdy_stall0 = 1'b1;
`else
    exp_rdy_stall0 = 1'b0;
`endif
    check("stall_rdy0", in_ready, exp_rdy_stall0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_out",   out,       64'hA5A5_A5A5_A5A5_A5A5);
      check("stall_valid", out_valid, 1'b1);
      check("stall_rdy",   in_ready,  1'b0);
    end
    out_ready = 1'b1;
    step();
    check("unstall_out", out,       64'h5A5A_5A5A_5A5A_5A5A);
    check("unstall_vld", out_valid, 1'b1);
    in_valid = 1'b0;
    step();
    check("unstall_drain", out_valid, 1'b0);

    // Streaming: 8 back-to-back words, alternating sel.
    for (int k = 0; k < 8; k++) begin
      sa0[k] = 64'h1000_0000_0000_0000 + 64'(k);
      sa1[k] = 64'h2000_0000_0000_0000 + 64'(k);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i0 = sa0[k]; i1 = sa1[k]; sel = k[0]; in_valid = 1'b1;
      #1;
      check("stream_rdy", in_ready, 1'b1);
      step();
      check("stream_vld", out_valid, 1'b1);
      check("stream_out", out, k[0] ? sa1[k] : sa0[k]);
    end
    in_valid = 1'b0;
    step();
    check("stream_end", out_valid, 1'b0);

    // Random handshake traffic against a queue scoreboard.
    held_v = 1'b0;
    held_w = '0;
    for (int c = 0; c < 1000; c++) begin
      i0        = {$urandom, $urandom};
      i1        = {$urandom, $urandom};
      s         = 1'($urandom_range(0, 1));
      sel       = s;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rnd_comb", comb_out, s ? i1 : i0);
      if (held_v) begin
        check("rnd_hold_vld", out_valid, 1'b1);
        check("rnd_hold_out", out, held_w);
      end
      if (out_valid && out_ready) begin
        if (sq.size() == 0) begin
          check("rnd_spurious", out_valid, 1'b0);
        end else begin
          exp_w = sq.pop_front();
          check("rnd_data", out, exp_w);
        end
      end
      held_v = out_valid && !out_ready;
      held_w = out;
      if (in_valid && in_ready) sq.push_back(s ? i1 : i0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        if (sq.size() == 0) begin
          check("drain_spurious", out_valid, 1'b0);
        end else begin
          exp_w = sq.pop_front();
          check("drain_data", out, exp_w);
        end
      end
      step();
    end
    check("drain_left", 32'(sq.size()), 32'd0);
    check("drain_vld",  out_valid,      1'b0);

    // Asynchronous reset with a buffered word.
    sel = 1'b1; i1 = 64'hCAFE_F00D_CAFE_F00D; in_valid = 1'b1; out_ready = 1'b0;
    step();
    check("pre_rst_vld", out_valid, 1'b1);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_vld",  out_valid, 1'b0);
    check("arst_out",  out,       '0);
    check("arst_rdy",  in_ready,  1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("arst_rel_rdy", in_ready,  1'b1);
    check("arst_rel_vld", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux2_1_pipe
